// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access-size codes, FSM states
// and the alignment helper used to flag misaligned accesses.
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } lsu_state_e;

    localparam int WORD_SHIFT = 2;

    function automatic logic is_subword(input logic [1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF);
    endfunction

    // Size code 11 behaves as a word access, so it needs full word alignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (size)
            SIZE_BYTE: r = 1'b0;
            SIZE_HALF: r = lo[0];
            default:   r = (lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_byte_lane.sv
// Byte-lane steering for the LSU: extracts and extends sub-word load data and merges
// sub-word store data into a previously read word (little-endian lanes).
module lsu_byte_lane
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load path: pick the addressed lane and sign- or zero-extend it
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = rdata_i[7:0];
        endcase
        if (addr_lo_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (size_i)
            SIZE_BYTE: load_data_o = {{24{~unsigned_i & byte_s[7]}}, byte_s};
            SIZE_HALF: load_data_o = {{16{~unsigned_i & half_s[15]}}, half_s};
            default:   load_data_o = rdata_i;
        endcase
    end

    // Store path: overwrite only the target lane(s) of the word just read
    always_comb begin
        merge_data_o = rdata_i;
        case (size_i)
            SIZE_BYTE: begin
                case (addr_lo_i)
                    2'b00:   merge_data_o[7:0]   = wdata_i[7:0];
                    2'b01:   merge_data_o[15:8]  = wdata_i[7:0];
                    2'b10:   merge_data_o[23:16] = wdata_i[7:0];
                    2'b11:   merge_data_o[31:24] = wdata_i[7:0];
                    default: merge_data_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (addr_lo_i[1]) begin
                    merge_data_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_data_o[15:0] = wdata_i[15:0];
                end
            end
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts EX/MEM entries, drives the word-wide data memory
// (sub-word stores via a two-cycle read-modify-write) and owns the MEM/WB register.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 63
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_load,
    input  logic                  in_store,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0]      in_wdata,
    input  logic [4:0]            in_rd,
    input  logic                  in_reg_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [4:0]            out_rd,
    output logic                  out_reg_write,
    output logic                  out_err
);

    lsu_state_e            state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_err_q, out_err_d;
    logic                  out_reg_write_q, out_reg_write_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic [4:0]            out_rd_q, out_rd_d;
    logic [WIDTH-1:0]      merge_q, merge_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [4:0]            rd_q, rd_d;

    logic                  fire_s;
    logic                  err_s;
    logic                  subword_s;
    logic                  rmw_s;
    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic [WIDTH-1:0]      load_data_s;
    logic [WIDTH-1:0]      merge_data_s;

    assign word_idx_s = in_addr >> WORD_SHIFT;
    assign subword_s  = is_subword(in_size);
    assign err_s      = (in_load | in_store) &
                        (misaligned(in_size, in_addr[1:0]) | (word_idx_s >= ADDR_WIDTH'(DEPTH)));
    assign rmw_s      = (state_q == ST_RMW_WR);

    assign in_ready = reset & ~rmw_s & (~out_valid_q | out_ready);
    assign fire_s   = in_valid & in_ready;

    // While reset is low both enables are forced off, abandoning any pending RMW write.
    assign mem_ren   = fire_s & ~err_s & (in_load | (in_store & subword_s));
    assign mem_wen   = reset & (rmw_s | (fire_s & ~err_s & in_store & ~subword_s));
    assign mem_addr  = rmw_s ? (addr_q >> WORD_SHIFT) : word_idx_s;
    assign mem_wdata = rmw_s ? merge_q : in_wdata;

    assign out_valid     = out_valid_q;
    assign out_err       = out_err_q;
    assign out_reg_write = out_reg_write_q;
    assign out_data      = out_data_q;
    assign out_rd        = out_rd_q;

    lsu_byte_lane u_lane (
        .addr_lo_i    (in_addr[1:0]),
        .size_i       (in_size),
        .unsigned_i   (in_unsigned),
        .rdata_i      (mem_rdata),
        .wdata_i      (in_wdata),
        .load_data_o  (load_data_s),
        .merge_data_o (merge_data_s)
    );

    // Next-state for the FSM, RMW holding registers and MEM/WB entry
    always_comb begin
        state_d         = state_q;
        out_valid_d     = out_valid_q;
        out_err_d       = out_err_q;
        out_reg_write_d = out_reg_write_q;
        out_data_d      = out_data_q;
        out_rd_d        = out_rd_q;
        merge_d         = merge_q;
        addr_d          = addr_q;
        rd_d            = rd_q;
        if (rmw_s) begin
            // Slot was freed when the RMW was accepted, so this write never stalls.
            state_d         = ST_IDLE;
            out_valid_d     = 1'b1;
            out_err_d       = 1'b0;
            out_reg_write_d = 1'b0;
            out_data_d      = addr_q;
            out_rd_d        = rd_q;
        end else if (fire_s) begin
            if (err_s) begin
                out_valid_d     = 1'b1;
                out_err_d       = 1'b1;
                out_reg_write_d = 1'b0;
                out_data_d      = in_addr;
                out_rd_d        = in_rd;
            end else if (in_store && subword_s) begin
                state_d     = ST_RMW_WR;
                merge_d     = merge_data_s;
                addr_d      = in_addr;
                rd_d        = in_rd;
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b1;
                out_err_d   = 1'b0;
                out_rd_d    = in_rd;
                if (in_load) begin
                    out_data_d      = load_data_s;
                    out_reg_write_d = in_reg_write;
                end else if (in_store) begin
                    out_data_d      = in_addr;
                    out_reg_write_d = 1'b0;
                end else begin
                    out_data_d      = in_addr;
                    out_reg_write_d = in_reg_write;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and MEM/WB registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            out_valid_q     <= 1'b0;
            out_err_q       <= 1'b0;
            out_reg_write_q <= 1'b0;
            out_data_q      <= '0;
            out_rd_q        <= 5'd0;
            merge_q         <= '0;
            addr_q          <= '0;
            rd_q            <= 5'd0;
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            out_err_q       <= out_err_d;
            out_reg_write_q <= out_reg_write_d;
            out_data_q      <= out_data_d;
            out_rd_q        <= out_rd_d;
            merge_q         <= merge_d;
            addr_q          <= addr_d;
            rd_q            <= rd_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu paired with a 63-word data memory; expected results
// come from a byte-array reference model updated in program order at each accept.
module tb_mem_stage_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_load, in_store, in_unsigned, in_reg_write;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen, mem_ren;
    logic        out_valid, out_ready, out_reg_write, out_err;
    logic [31:0] out_data;
    logic [4:0]  out_rd;

    always #5 clock = ~clock;

    mem_stage_lsu #(.WIDTH(32), .ADDR_WIDTH(32), .DEPTH(63)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_err(out_err)
    );

    // Data memory: combinational read, write on the clock edge
    logic [31:0] dmem [0:62];
    assign mem_rdata = (mem_ren && mem_addr < 32'd63) ? dmem[mem_addr[5:0]] : 32'h0;
    always @(posedge clock) begin
        if (mem_wen && mem_addr < 32'd63) dmem[mem_addr[5:0]] <= mem_wdata;
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        err;
        int          due;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  ref_b [0:251];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          rand_rdy = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    // Issue one instruction; the reference model decides the expected MEM/WB entry at accept
    task automatic send(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input bit rw);
        exp_t        e;
        int unsigned a;
        int          nbytes;
        bit          is_err, done;
        logic [31:0] val;
        @(negedge clock);
        in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
        in_addr = addr; in_wdata = wdata; in_rd = rd; in_reg_write = rw;
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (in_ready) begin
                done   = 1'b1;
                a      = addr;
                nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
                is_err = (ld || st) && ((a % nbytes) != 0 || a / 4 >= 63);
                e.data = addr; e.rd = rd; e.rw = rw; e.err = 1'b0; e.due = cyc + 1;
                if (is_err) begin
                    e.err = 1'b1; e.rw = 1'b0;
                    check("err_no_ren", {31'd0, mem_ren}, 32'd0);
                    check("err_no_wen", {31'd0, mem_wen}, 32'd0);
                end else if (ld) begin
                    val = 32'd0;
                    for (int k = 0; k < nbytes; k++) val |= 32'(ref_b[a + k]) << (8 * k);
                    if (!uns && nbytes < 4 && val[8*nbytes-1]) val |= 32'hFFFFFFFF << (8 * nbytes);
                    e.data = val;
                    check("load_ren", {31'd0, mem_ren}, 32'd1);
                    check("load_addr", mem_addr, a / 4);
                end else if (st) begin
                    for (int k = 0; k < nbytes; k++) ref_b[a + k] = 8'(wdata >> (8 * k));
                    e.rw = 1'b0;
                    if (nbytes < 4) begin
                        e.due = cyc + 2;
                        check("rmw1_ren", {31'd0, mem_ren}, 32'd1);
                        check("rmw1_no_wen", {31'd0, mem_wen}, 32'd0);
                    end else begin
                        check("sw_wen", {30'd0, mem_wen, mem_ren}, 32'd2);
                        check("sw_wdata", mem_wdata, wdata);
                    end
                end else begin
                    check("op_no_mem", {30'd0, mem_wen, mem_ren}, 32'd0);
                end
                expq.push_back(e);
                @(posedge clock);
                #1 in_valid = 1'b0;
                if (st && !is_err && nbytes < 4) begin
                    @(negedge clock);
                    #1;
                    check("rmw2_in_ready", {31'd0, in_ready}, 32'd0);
                    check("rmw2_wen_ren", {30'd0, mem_wen, mem_ren}, 32'd2);
                    check("rmw2_addr", mem_addr, a / 4);
                    check("rmw2_wdata", mem_wdata, ref_word(a / 4));
                end
            end else begin
                @(negedge clock);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=no_accept expected=accept addr=%h", addr);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clock);
        check("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever an entry is consumed at the coming edge
    initial begin : monitor
        bit   seen;
        int   seen_cyc;
        exp_t e;
        seen = 1'b0; seen_cyc = 0;
        forever begin
            @(negedge clock);
            #4;
            if (reset === 1'b1) begin
                if (mem_wen && mem_ren) check("wen_ren_excl", 32'd1, 32'd0);
                if (out_valid && !seen) begin seen = 1'b1; seen_cyc = cyc; end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        check("unexpected_out", {31'd0, out_valid}, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                        check("out_rw", {31'd0, out_reg_write}, {31'd0, e.rw});
                        check("out_err", {31'd0, out_err}, {31'd0, e.err});
                        check("latency", seen_cyc, e.due);
                    end
                    seen = 1'b0;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin : rdy_gen
        forever begin
            @(negedge clock);
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : main
        logic [31:0] w, held, addr;
        logic [1:0]  sz;
        int          kind;
        reset = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd2; in_unsigned = 1'b0;
        in_addr = 32'h0; in_wdata = 32'h0; in_rd = 5'd0; in_reg_write = 1'b1;
        for (int i = 0; i < 63; i++) begin
            w = $urandom;
            dmem[i] = w;
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = 8'(w >> (8 * k));
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_en", {30'd0, mem_wen, mem_ren}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_out_rw_err", {30'd0, out_reg_write, out_err}, 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;

        send(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 5'd1, 1);
        send(1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd2, 1);
        send(1, 0, 2'd0, 0, 32'h13, 32'h0, 5'd3, 1);
        send(1, 0, 2'd0, 1, 32'h13, 32'h0, 5'd4, 1);
        send(1, 0, 2'd1, 0, 32'h10, 32'h0, 5'd5, 1);
        send(0, 1, 2'd0, 0, 32'h11, 32'h12345677, 5'd6, 1);
        send(1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd7, 1);
        check("sb_mem_word", dmem[4], 32'hDEAD77EF);
        send(1, 0, 2'd1, 0, 32'h11, 32'h0, 5'd8, 1);
        send(1, 0, 2'd2, 0, 32'h12, 32'h0, 5'd9, 1);
        send(1, 0, 2'd2, 0, 32'h100, 32'h0, 5'd10, 1);
        send(0, 0, 2'd3, 0, 32'h12345679, 32'h0, 5'd11, 1);
        drain();

        // Back-pressure: one load held in MEM/WB, a second waits for the slot
        out_ready = 1'b0;
        send(1, 0, 2'd2, 0, 32'h20, 32'h0, 5'd12, 1);
        held = expq[expq.size() - 1].data;
        fork
            send(1, 0, 2'd0, 1, 32'h21, 32'h0, 5'd13, 1);
            begin
                repeat (3) begin
                    @(negedge clock);
                    #2;
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_out_data", out_data, held);
                end
                @(negedge clock);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset during the write cycle of a halfword RMW
        @(negedge clock);
        in_valid = 1'b1; in_load = 1'b0; in_store = 1'b1; in_size = 2'd1; in_unsigned = 1'b0;
        in_addr = 32'h20; in_wdata = 32'hCAFEF00D; in_rd = 5'd14; in_reg_write = 1'b1;
        #1 check("rstrmw_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1 check("rstrmw_no_wen", {30'd0, mem_wen, mem_ren}, 32'd0);
        @(posedge clock);
        #1 check("rstrmw_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        check("rstrmw_mem_kept", dmem[8], ref_word(8));

        rand_rdy = 1'b1;
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 259));
            if ($urandom_range(0, 3) != 0) begin
                addr = (sz == 2'd0) ? addr : (sz == 2'd1) ? (addr & ~32'd1) : (addr & ~32'd3);
            end
            send(kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)), addr, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        @(posedge clock);
        #1 out_ready = 1'b1;
        drain();
        for (int i = 0; i < 63; i++) begin
            if (dmem[i] !== ref_word(i)) check("final_mem", dmem[i], ref_word(i));
        end
        check("final_mem_w4", dmem[4], ref_word(4));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
